pipeline_trace_buffer: RTL and testbench

- Synthesizable debug block that snoops the register-file write-back port and PC of the 5-stage MIPS pipeline.
- Records filtered register writes into a parametrised circular trace buffer, starting on a PC trigger.
- Each record holds a cycle stamp, PC, register number and data. Records drain through a valid/ready readout port.
- Replaces per-cycle dumps of fixed registers. Instantiated beside the register file inside Pipeline.

---
 rtl/pipeline_trace_pkg.sv | 23 ++
 rtl/pipeline_trace_buffer_ram.sv | 24 ++
 rtl/pipeline_trace_buffer.sv | 132 +++++++++++++
 tb/tb_pipeline_trace_buffer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_trace_pkg.sv
// Shared types and constants for the write-back trace buffer.
// State encoding, register numbers, default watch mask, field widths.
package pipeline_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } trace_state_e;

  localparam int REG_W  = 5;
  localparam int REG_T0 = 8;
  localparam int REG_S0 = 16;
  localparam int REG_T8 = 24;

  localparam logic [31:0] DEF_WATCH_MASK = 32'h03FF_FF00;

  localparam int DEF_PC_W    = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_STAMP_W = 16;

endpackage

// File: rtl/pipeline_trace_buffer_ram.sv
// Trace storage: DEPTH x W, synchronous write, asynchronous read.
// Ports: clock, i_we/i_waddr/i_wdata write, i_raddr/o_rdata read.
module trace_ram #(
  parameter int DEPTH = 64,
  parameter int W     = 85,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pipeline_trace_buffer.sv
// Write-back trace buffer: PC-triggered capture of watched register writes.
// Ports: arm/stop/trigger control, wb snoop, valid/ready readout, status.
module pipeline_trace_buffer
  import pipeline_trace_pkg::*;
#(
  parameter int          PC_W       = DEF_PC_W,
  parameter int          DATA_W     = DEF_DATA_W,
  parameter int          DEPTH      = 64,
  parameter int          STAMP_W    = DEF_STAMP_W,
  parameter logic [31:0] WATCH_MASK = DEF_WATCH_MASK,
  parameter int          WRAP_MODE  = 0,
  parameter int          CW         = $clog2(DEPTH) + 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               arm,
  input  logic               stop,
  input  logic               trig_en,
  input  logic [PC_W-1:0]    trig_pc,
  input  logic [PC_W-1:0]    pc,
  input  logic               wb_en,
  input  logic [REG_W-1:0]   wb_addr,
  input  logic [DATA_W-1:0]  wb_data,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [STAMP_W-1:0] rd_stamp,
  output logic [PC_W-1:0]    rd_pc,
  output logic [REG_W-1:0]   rd_reg,
  output logic [DATA_W-1:0]  rd_data,
  output logic [CW-1:0]      count,
  output logic [1:0]         state,
  output logic               overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = STAMP_W + PC_W + REG_W + DATA_W;

  trace_state_e       r_state;
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic               r_overflow;
  logic [STAMP_W-1:0] r_stamp;

  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_arm_ok;
  logic [CW-1:0] w_cnt_nxt;
  logic [RW-1:0] w_wrec;
  logic [RW-1:0] w_rrec;

  assign w_push = (r_state == ST_CAPTURE) && wb_en &&
                  (wb_addr != '0) && WATCH_MASK[wb_addr];
  assign w_pop  = (r_count != '0) && rd_ready;
  assign w_full = (r_count == CW'(DEPTH));
  assign w_arm_ok = arm &&
                    ((r_state == ST_IDLE) || (r_state == ST_DONE));

  // Push into a full buffer (wrap mode) keeps count at DEPTH.
  always_comb begin
    w_cnt_nxt = r_count;
    if (w_push && !w_pop && !w_full)
      w_cnt_nxt = r_count + CW'(1);
    else if (!w_push && w_pop)
      w_cnt_nxt = r_count - CW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_stamp    <= '0;
    end else begin
      r_stamp <= r_stamp + STAMP_W'(1);
      if (w_arm_ok) begin
        r_state    <= ST_ARMED;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_count    <= '0;
        r_overflow <= 1'b0;
      end else begin
        if (w_push)
          r_wr_ptr <= r_wr_ptr + AW'(1);
        // Overwriting the oldest entry drags the read side along.
        if (w_pop || (w_push && w_full))
          r_rd_ptr <= r_rd_ptr + AW'(1);
        r_count <= w_cnt_nxt;
        if (w_push && w_full && !w_pop)
          r_overflow <= 1'b1;
        unique case (r_state)
          ST_ARMED: begin
            if (stop)
              r_state <= ST_DONE;
            else if (!trig_en || (pc == trig_pc))
              r_state <= ST_CAPTURE;
          end
          ST_CAPTURE: begin
            if (stop ||
                (WRAP_MODE == 0 && w_cnt_nxt == CW'(DEPTH)))
              r_state <= ST_DONE;
          end
          ST_IDLE, ST_DONE: ;
        endcase
      end
    end
  end

  assign w_wrec = {r_stamp, pc, wb_addr, wb_data};

  trace_ram #(
    .DEPTH (DEPTH),
    .W     (RW)
  ) u_ram (
    .clock   (clock),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wrec),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rrec)
  );

  assign {rd_stamp, rd_pc, rd_reg, rd_data} = w_rrec;
  assign rd_valid = (r_count != '0);
  assign count    = r_count;
  assign state    = r_state;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// Directed bench for pipeline_trace_buffer.
// u0: DEPTH 4 stop-when-full, u1: DEPTH 4 wrap, u2: default DEPTH 64.
module tb_pipeline_trace_buffer;

  logic        clock = 0;
  logic        reset, arm, stop, trig_en, wb_en, rd_ready;
  logic [31:0] trig_pc, pc, wb_data;
  logic [4:0]  wb_addr;

  logic        v0, v1, v2;
  logic [15:0] s0, s1, s2;
  logic [31:0] p0, p1, p2, d0, d1, d2;
  logic [4:0]  g0, g1, g2;
  logic [2:0]  c0, c1;
  logic [6:0]  c2;
  logic [1:0]  st0, st1, st2;
  logic        o0, o1, o2;

  int npass = 0;
  int ntotal = 0;
  int cyc = 0;
  logic [15:0] exp_stamp;
  logic [15:0] hold_stamp;

  always #5 clock = ~clock;

  pipeline_trace_buffer #(.DEPTH(4), .WRAP_MODE(0)) u0 (
    .clock(clock), .reset(reset), .arm(arm), .stop(stop),
    .trig_en(trig_en), .trig_pc(trig_pc), .pc(pc),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .rd_valid(v0), .rd_ready(rd_ready), .rd_stamp(s0),
    .rd_pc(p0), .rd_reg(g0), .rd_data(d0),
    .count(c0), .state(st0), .overflow(o0));

  pipeline_trace_buffer #(.DEPTH(4), .WRAP_MODE(1)) u1 (
    .clock(clock), .reset(reset), .arm(arm), .stop(stop),
    .trig_en(trig_en), .trig_pc(trig_pc), .pc(pc),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .rd_valid(v1), .rd_ready(rd_ready), .rd_stamp(s1),
    .rd_pc(p1), .rd_reg(g1), .rd_data(d1),
    .count(c1), .state(st1), .overflow(o1));

  pipeline_trace_buffer u2 (
    .clock(clock), .reset(reset), .arm(arm), .stop(stop),
    .trig_en(trig_en), .trig_pc(trig_pc), .pc(pc),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .rd_valid(v2), .rd_ready(rd_ready), .rd_stamp(s2),
    .rd_pc(p2), .rd_reg(g2), .rd_data(d2),
    .count(c2), .state(st2), .overflow(o2));

  task automatic tick();
    @(posedge clock);
    if (reset) cyc = 0;
    else cyc = cyc + 1;
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1; wb_addr = a; wb_data = d;
    tick();
    wb_en = 0;
  endtask

  initial begin
    reset = 1; arm = 0; stop = 0; trig_en = 0; rd_ready = 0;
    trig_pc = 0; pc = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
    tick(); tick();
    reset = 0;
    chk("rst_state", st2, 0);
    chk("rst_count", c2, 0);
    chk("rst_valid", v2, 0);
    chk("rst_ovf", o1, 0);

    // PC trigger
    arm = 1; trig_en = 1; trig_pc = 32'h10;
    tick();
    arm = 0;
    chk("armed", st2, 1);
    wb_en = 1; wb_addr = 16;
    for (int p = 0; p <= 16; p += 4) begin
      pc = p; wb_data = p;
      tick();
      if (p < 16) chk("wait_trig", st2, 1);
    end
    chk("trig_state", st2, 2);
    chk("trig_nocap", c2, 0);
    pc = 32'h14; wb_data = 32'h14; exp_stamp = 16'(cyc);
    tick();
    wb_en = 0;
    chk("trig_cnt", c2, 1);
    chk("trig_pc", p2, 32'h14);
    chk("trig_reg", g2, 16);
    chk("trig_stamp", s2, exp_stamp);
    chk("trig_data", d2, 32'h14);
    stop = 1; tick(); stop = 0;
    chk("stop_done", st2, 3);
    rd_ready = 1; tick(); rd_ready = 0;
    chk("drain_valid", v2, 0);

    // Register filter
    arm = 1; trig_en = 0; tick(); arm = 0;
    tick();
    chk("imm_trig", st2, 2);
    wr(0, 32'h11);
    wr(1, 32'h22);
    wr(16, 32'hAB);
    chk("flt_cnt", c2, 1);
    chk("flt_reg", g2, 16);
    chk("flt_data", d2, 32'hAB);
    stop = 1; tick(); stop = 0;
    rd_ready = 1; tick(); rd_ready = 0;

    // Full behaviour, both modes
    arm = 1; tick(); arm = 0;
    tick();
    for (int d = 1; d <= 6; d++) begin
      wr(8, d);
      if (d == 4) chk("full_done4", st0, 3);
    end
    chk("nw_cnt", c0, 4);
    chk("nw_state", st0, 3);
    chk("nw_ovf", o0, 0);
    chk("w_cnt", c1, 4);
    chk("w_ovf", o1, 1);
    chk("w_state", st1, 2);
    chk("big_cnt", c2, 6);
    stop = 1; tick(); stop = 0;
    chk("w_done", st1, 3);
    rd_ready = 1;
    for (int k = 0; k < 4; k++) begin
      chk("nw_order", d0, k + 1);
      chk("w_order", d1, k + 3);
      tick();
    end
    rd_ready = 0;
    chk("nw_empty", v0, 0);
    chk("w_empty", v1, 0);
    chk("big_left", c2, 2);

    // Reset in the middle of capture
    arm = 1; tick(); arm = 0;
    tick();
    for (int d = 1; d <= 5; d++) wr(8, 32'h40 + d);
    chk("mid_cnt5", c2, 5);
    chk("mid_cap", st2, 2);
    chk("mid_w_ovf", o1, 1);
    reset = 1; tick(); reset = 0;
    chk("mr_state", st2, 0);
    chk("mr_count", c2, 0);
    chk("mr_valid", v2, 0);
    chk("mr_ovf", o1, 0);
    chk("mr_cnt1", c1, 0);

    // Full wrap buffer: push and pop together, stable hold
    arm = 1; tick(); arm = 0;
    tick();
    for (int d = 0; d < 4; d++) wr(8, 32'h21 + d);
    chk("pp_full", c1, 4);
    chk("pp_ovf0", o1, 0);
    hold_stamp = s1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("hold_data", d1, 32'h21);
      chk("hold_stamp", s1, hold_stamp);
    end
    wb_en = 1; wb_addr = 8; wb_data = 32'h25; rd_ready = 1;
    chk("pp_oldest", d1, 32'h21);
    tick();
    wb_en = 0; rd_ready = 0;
    chk("pp_cnt", c1, 4);
    chk("pp_ovf", o1, 0);
    chk("pp_next", d1, 32'h22);
    chk("pp_nw_cnt", c0, 3);
    rd_ready = 1;
    tick(); tick(); tick();
    rd_ready = 0;
    chk("pp_last", d1, 32'h25);
    chk("pp_last_cnt", c1, 1);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
